// File: rtl/ads_sample_avg_if.sv
// Result bus of the decimating averager.
// Valid/ready handshake carrying window mean, min and max.
interface ads_sample_avg_if #(
  parameter int DW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_avg;
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;

  modport master (
    output out_valid,
    output out_avg,
    output out_min,
    output out_max,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_avg,
    input  out_min,
    input  out_max,
    output out_ready
  );
endinterface

// File: rtl/ads_sample_avg.sv
// Decimating averager behind the ADS8685 SPI front end.
// Averages 2^LOG2N samples (round-half-up), tracks min/max.
module ads_sample_avg #(
  parameter int DW    = 16,
  parameter int LOG2N = 3
) (
  input  logic          clk_ref,
  input  logic          sys_rst,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          overrun,
  ads_sample_avg_if.master out_if
);

  localparam int AW = DW + LOG2N;
  localparam int CW = LOG2N + 1;
  localparam logic [CW-1:0] WIN = CW'(2 ** LOG2N);
  localparam logic [AW-1:0] RND = AW'((2 ** LOG2N) / 2);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FLUSH
  } state_t;

  localparam state_t FIRST_ST = (LOG2N == 0) ? FLUSH : ACC;

  state_t        state;
  state_t        state_n;
  logic          dv_q;
  logic          ev;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_rnd;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [DW-1:0] mn;
  logic [DW-1:0] mx;
  logic [DW-1:0] avg;
  logic          ld_first;
  logic          ld_acc;
  logic          flush;
  logic          slot_free;

  assign ev        = din_valid & ~dv_q;
  assign cnt_inc   = cnt + CW'(1);
  assign acc_rnd   = acc + RND;
  assign avg       = acc_rnd[AW-1:LOG2N];
  assign slot_free = ~out_if.out_valid | out_if.out_ready;

  always_ff @(posedge clk_ref or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    ld_first = 1'b0;
    ld_acc   = 1'b0;
    flush    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ev) begin
          ld_first = 1'b1;
          state_n  = FIRST_ST;
        end
      end
      ACC: begin
        if (ev) begin
          ld_acc = 1'b1;
          if (cnt_inc == WIN) state_n = FLUSH;
        end
      end
      FLUSH: begin
        // A new window may open in the same cycle the old one drains
        flush    = 1'b1;
        ld_first = ev;
        state_n  = ev ? FIRST_ST : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_ref or posedge sys_rst) begin
    if (sys_rst) begin
      dv_q <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      mn   <= '0;
      mx   <= '0;
    end else begin
      dv_q <= din_valid;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (ld_first) begin
        acc <= AW'(din);
        mn  <= din;
        mx  <= din;
        cnt <= CW'(1);
      end else if (ld_acc) begin
        acc <= acc + AW'(din);
        mn  <= (din < mn) ? din : mn;
        mx  <= (din > mx) ? din : mx;
        cnt <= cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_ref or posedge sys_rst) begin
    if (sys_rst) begin
      out_if.out_valid <= 1'b0;
      out_if.out_avg   <= '0;
      out_if.out_min   <= '0;
      out_if.out_max   <= '0;
      overrun          <= 1'b0;
    end else if (clr) begin
      out_if.out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else if (flush && slot_free) begin
      out_if.out_valid <= 1'b1;
      out_if.out_avg   <= avg;
      out_if.out_min   <= mn;
      out_if.out_max   <= mx;
    end else begin
      if (flush) overrun <= 1'b1;
      if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ads_sample_avg.sv
// Bench for ads_sample_avg: four window sizes share one stream.
// Queue-based window model feeds a scoreboard per instance.
module tb_ads_sample_avg;

  localparam int DW = 16;
  localparam int ND = 4;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] mn;
    logic [15:0] mx;
  } res_t;

  logic        clk_ref = 1'b0;
  logic        sys_rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] din = '0;
  logic        clr = 1'b0;
  logic        rdy [ND];
  bit          rand_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_ref = ~clk_ref;

  task automatic chk(input string nm, input int k,
                     input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h",
               nm, k, act, exp);
    end
  endtask

  function automatic res_t summarize(input int w[$], input int lg);
    res_t   r;
    longint s;
    int     lo;
    int     hi;
    s  = 0;
    lo = w[0];
    hi = w[0];
    foreach (w[i]) begin
      s += w[i];
      if (w[i] < lo) lo = w[i];
      if (w[i] > hi) hi = w[i];
    end
    r.a  = 16'((s + ((longint'(1) << lg) / 2)) / (longint'(1) << lg));
    r.mn = 16'(lo);
    r.mx = 16'(hi);
    return r;
  endfunction

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LG = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
    localparam int N  = 1 << LG;

    ads_sample_avg_if #(.DW(DW)) bus ();
    logic ovr;
    assign bus.out_ready = rdy[g];

    ads_sample_avg #(
      .DW   (DW),
      .LOG2N(LG)
    ) u_dut (
      .clk_ref  (clk_ref),
      .sys_rst  (sys_rst),
      .din_valid(din_valid),
      .din      (din),
      .clr      (clr),
      .overrun  (ovr),
      .out_if   (bus)
    );

    res_t exp_q[$];
    int   win[$];
    bit   pend = 1'b0;
    res_t pend_r;
    bit   m_valid = 1'b0;
    bit   m_ovr = 1'b0;
    bit   m_dvq = 1'b0;

    // Predictor: window-level behaviour, one step per clock edge
    initial forever begin
      @(posedge clk_ref or posedge sys_rst);
      if (sys_rst) begin
        win.delete();
        exp_q.delete();
        pend    = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_dvq   = 1'b0;
      end else if (clr) begin
        win.delete();
        if (m_valid) void'(exp_q.pop_back());
        pend    = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_dvq   = din_valid;
      end else begin
        if (pend) begin
          if (!m_valid || rdy[g]) begin
            exp_q.push_back(pend_r);
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          pend = 1'b0;
        end else if (m_valid && rdy[g]) begin
          m_valid = 1'b0;
        end
        if (din_valid && !m_dvq) begin
          win.push_back(int'(din));
          if (win.size() == N) begin
            pend_r = summarize(win, LG);
            pend   = 1'b1;
            win.delete();
          end
        end
        m_dvq = din_valid;
      end
    end

    // Monitor: pops an expectation on every accepted result
    initial forever begin
      res_t r;
      @(negedge clk_ref);
      chk("out_valid", g, longint'(bus.out_valid), longint'(m_valid));
      chk("overrun", g, longint'(ovr), longint'(m_ovr));
      if (bus.out_valid && rdy[g] && !clr && !sys_rst) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result dut%0d: got avg 0x%0h, expected none",
                   g, bus.out_avg);
        end else begin
          r = exp_q.pop_front();
          chk("sb_avg", g, longint'(bus.out_avg), longint'(r.a));
          chk("sb_min", g, longint'(bus.out_min), longint'(r.mn));
          chk("sb_max", g, longint'(bus.out_max), longint'(r.mx));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_ref);
    #2;
    if (rand_rdy) begin
      for (int k = 0; k < ND; k++) rdy[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic pulse(input logic [15:0] v, input int hi, input int lo);
    din       = v;
    din_valid = 1'b1;
    repeat (hi) step();
    din_valid = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < ND; k++) rdy[k] = 1'b1;
    #1 sys_rst = 1'b1;
    repeat (3) step();
    chk("rst_valid", 2, longint'(g_dut[2].bus.out_valid), 0);
    chk("rst_avg", 2, longint'(g_dut[2].bus.out_avg), 0);
    chk("rst_min", 2, longint'(g_dut[2].bus.out_min), 0);
    chk("rst_max", 2, longint'(g_dut[2].bus.out_max), 0);
    chk("rst_ovr", 1, longint'(g_dut[1].ovr), 0);

    // Level already high at reset release is one event
    din       = 16'd7;
    din_valid = 1'b1;
    sys_rst   = 1'b0;
    repeat (5) step();
    din_valid = 1'b0;
    repeat (3) step();
    chk("rel_event_avg", 0, longint'(g_dut[0].bus.out_avg), 7);

    // Basic average
    do_clr();
    pulse(16'd100, 60, 74);
    pulse(16'd200, 60, 74);
    pulse(16'd300, 60, 74);
    pulse(16'd401, 60, 74);
    chk("basic_avg", 2, longint'(g_dut[2].bus.out_avg), 250);
    chk("basic_min", 2, longint'(g_dut[2].bus.out_min), 100);
    chk("basic_max", 2, longint'(g_dut[2].bus.out_max), 401);

    // Level vs edge
    do_clr();
    pulse(16'h1234, 500, 10);
    repeat (3) pulse(16'h1234, 3, 3);
    chk("level_avg", 2, longint'(g_dut[2].bus.out_avg), 'h1234);

    // Overrun
    do_clr();
    rdy[1] = 1'b0;
    pulse(16'd10, 2, 3);
    pulse(16'd20, 2, 3);
    pulse(16'd30, 2, 3);
    pulse(16'd40, 2, 3);
    chk("ovr_valid", 1, longint'(g_dut[1].bus.out_valid), 1);
    chk("ovr_avg", 1, longint'(g_dut[1].bus.out_avg), 15);
    chk("ovr_flag", 1, longint'(g_dut[1].ovr), 1);
    rdy[1] = 1'b1;
    step();
    rdy[1] = 1'b0;
    chk("ovr_drop_valid", 1, longint'(g_dut[1].bus.out_valid), 0);
    chk("ovr_sticky", 1, longint'(g_dut[1].ovr), 1);
    do_clr();
    chk("ovr_clr", 1, longint'(g_dut[1].ovr), 0);

    // Accept and load in the same cycle
    do_clr();
    pulse(16'd500, 2, 3);
    pulse(16'd502, 2, 3);
    pulse(16'd1000, 2, 3);
    din       = 16'd1003;
    din_valid = 1'b1;
    step();
    rdy[1] = 1'b1;
    step();
    rdy[1] = 1'b0;
    chk("al_valid", 1, longint'(g_dut[1].bus.out_valid), 1);
    chk("al_avg", 1, longint'(g_dut[1].bus.out_avg), 1002);
    chk("al_ovr", 1, longint'(g_dut[1].ovr), 0);
    din_valid = 1'b0;
    step();
    rdy[1] = 1'b1;
    step();

    // clr and reset mid-window
    do_clr();
    pulse(16'd50, 2, 2);
    pulse(16'd60, 2, 2);
    do_clr();
    repeat (4) pulse(16'd8, 2, 2);
    chk("clr_avg", 2, longint'(g_dut[2].bus.out_avg), 8);
    pulse(16'd50, 2, 2);
    pulse(16'd60, 2, 2);
    sys_rst = 1'b1;
    step();
    chk("mid_rst_avg", 2, longint'(g_dut[2].bus.out_avg), 0);
    chk("mid_rst_max", 2, longint'(g_dut[2].bus.out_max), 0);
    chk("mid_rst_avg", 0, longint'(g_dut[0].bus.out_avg), 0);
    sys_rst = 1'b0;
    step();
    repeat (4) pulse(16'd8, 2, 2);
    chk("rst_win_avg", 2, longint'(g_dut[2].bus.out_avg), 8);
    chk("rst_win_min", 2, longint'(g_dut[2].bus.out_min), 8);

    // Extremes
    do_clr();
    repeat (256) pulse(16'hFFFF, 1, 1);
    repeat (3) step();
    chk("max_avg", 3, longint'(g_dut[3].bus.out_avg), 'hFFFF);
    chk("max_min", 3, longint'(g_dut[3].bus.out_min), 'hFFFF);
    pulse(16'h0ABC, 1, 2);
    chk("n1_avg", 0, longint'(g_dut[0].bus.out_avg), 'h0ABC);
    chk("n1_max", 0, longint'(g_dut[0].bus.out_max), 'h0ABC);

    // Randomized traffic with random back-pressure
    do_clr();
    rand_rdy = 1'b1;
    repeat (400) begin
      if ($urandom_range(0, 59) == 0) do_clr();
      pulse(16'($urandom), $urandom_range(1, 6), $urandom_range(1, 6));
    end
    rand_rdy = 1'b0;
    for (int k = 0; k < ND; k++) rdy[k] = 1'b1;
    repeat (10) step();
    chk("drain", 0, longint'(g_dut[0].exp_q.size()), 0);
    chk("drain", 1, longint'(g_dut[1].exp_q.size()), 0);
    chk("drain", 2, longint'(g_dut[2].exp_q.size()), 0);
    chk("drain", 3, longint'(g_dut[3].exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
